// File: rtl/rnd_range_sampler.sv
// Mask-rejection sampler: turns raw 32-bit uniform words into unbiased integers
// in [0, bound) and queues them in a small FIFO behind a valid/ready port.
module rnd_range_sampler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      rnd_in,
  input  logic             rnd_valid,
  input  logic [31:0]      bound_in,
  input  logic             bound_load,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] reject_count,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_q, state_d;
  logic [31:0]                bound_q, bound_d;
  logic [31:0]                mask_q, mask_d;
  logic [AW:0]                wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DEPTH-1:0][31:0]     mem_q;

  logic        empty, full, pop, eval, accept, push;
  logic [31:0] cand;

  // Smallest all-ones mask covering bound-1; bound 0 selects the full word.
  function automatic logic [31:0] range_mask(input logic [31:0] b);
    logic [31:0] x;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    x = b - 32'd1;
    x = x | (x >> 1);
    x = x | (x >> 2);
    x = x | (x >> 4);
    x = x | (x >> 8);
    x = x | (x >> 16);
    return x;
  endfunction

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign cand   = rnd_in & mask_q;
  assign accept = (bound_q == 32'd0) || (cand < bound_q);
  // A load cycle neither evaluates nor pops: the FIFO is being flushed.
  assign eval   = (state_q == RUN) && rnd_valid && !full && !bound_load;
  assign push   = eval && accept;
  assign pop    = !empty && out_ready && !bound_load;

  assign out_valid    = !empty;
  assign out_data     = empty ? 32'd0 : mem_q[rd_q[AW-1:0]];
  assign reject_count = cnt_q;
  assign busy         = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (bound_load) begin
      state_d = RUN;
      bound_d = bound_in;
      mask_d  = range_mask(bound_in);
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (eval && !accept && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bound_q <= '0;
      mask_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bound_q <= bound_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset; out_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= cand;
  end

endmodule

// File: tb/tb_rnd_range_sampler.sv
// Directed bench for rnd_range_sampler: hand-computed vectors plus a taus113
// driven soak with bound 1000.
module tb_rnd_range_sampler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic [31:0] bound_in;
  logic        bound_load;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] reject_count;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [31:0] z1, z2, z3, z4;

  rnd_range_sampler #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .bound_in(bound_in), .bound_load(bound_load), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reject_count(reject_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] b);
    bound_in   = b;
    bound_load = 1'b1;
    tick();
    bound_load = 1'b0;
  endtask

  function automatic logic [31:0] taus_next();
    logic [31:0] b;
    b  = ((z1 << 6) ^ z1) >> 13;  z1 = ((z1 & 32'hFFFF_FFFE) << 18) ^ b;
    b  = ((z2 << 2) ^ z2) >> 27;  z2 = ((z2 & 32'hFFFF_FFF8) << 2)  ^ b;
    b  = ((z3 << 13) ^ z3) >> 21; z3 = ((z3 & 32'hFFFF_FFF0) << 7)  ^ b;
    b  = ((z4 << 3) ^ z4) >> 12;  z4 = ((z4 & 32'hFFFF_FF80) << 13) ^ b;
    return z1 ^ z2 ^ z3 ^ z4;
  endfunction

  initial begin
    int bad_any, accepted, out_of_range;
    rst_n = 1'b0; rnd_in = '0; rnd_valid = 1'b0; bound_in = '0;
    bound_load = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rej", 32'(reject_count), 32'd0);
    rst_n = 1'b1;

    // Idle: no sampling without a loaded bound.
    bad_any = 0;
    rnd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rnd_in = $urandom;
      tick();
      if (out_valid || busy || reject_count != 0) bad_any++;
    end
    chk("idle_quiet", 32'(bad_any), 32'd0);

    // bound=10, mask 0xF; load-cycle word is ignored.
    rnd_in = 32'h0000_0001;
    load(32'd10);
    chk("ld10_busy", 32'(busy), 32'd1);
    chk("ld10_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    rnd_in = 32'h0000_0003; tick();
    chk("b10_v3", 32'(out_valid), 32'd1);
    chk("b10_d3", out_data, 32'd3);
    rnd_in = 32'h0000_000C; tick();
    chk("b10_rej_v", 32'(out_valid), 32'd0);
    chk("b10_rej_c", 32'(reject_count), 32'd1);
    rnd_in = 32'hFFFF_FFF9; tick();
    chk("b10_d9", out_data, 32'd9);
    chk("b10_rej_c2", 32'(reject_count), 32'd1);
    rnd_valid = 1'b0; tick();
    chk("b10_drain", 32'(out_valid), 32'd0);

    // bound=0 pass-through, bound=1 always zero.
    load(32'd0);
    rnd_valid = 1'b1;
    rnd_in = 32'hDEAD_BEEF; tick();
    chk("b0_d1", out_data, 32'hDEAD_BEEF);
    rnd_in = 32'hCAFE_BABE; tick();
    chk("b0_d2", out_data, 32'hCAFE_BABE);
    chk("b0_rej", 32'(reject_count), 32'd0);
    load(32'd1);
    rnd_in = 32'hFFFF_FFFF; tick();
    chk("b1_v", 32'(out_valid), 32'd1);
    chk("b1_d", out_data, 32'd0);

    // bound=16, consumer stalled: fill, drop words 4 and 5, then drain in order.
    rnd_valid = 1'b0; out_ready = 1'b0;
    load(32'd16);
    rnd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rnd_in = 32'(i);
      tick();
      if (i == 0) chk("full_first", out_data, 32'd0);
    end
    chk("full_v", 32'(out_valid), 32'd1);
    chk("full_head", out_data, 32'd0);
    chk("full_rej", 32'(reject_count), 32'd0);
    rnd_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("drain_%0d", i), out_data, 32'(i));
    end
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Reload with 3 queued and 2 rejects; then bound=17, mask 0x1F.
    out_ready = 1'b0;
    load(32'd10);
    rnd_valid = 1'b1;
    rnd_in = 32'd1;  tick();
    rnd_in = 32'd12; tick();
    rnd_in = 32'd2;  tick();
    rnd_in = 32'd13; tick();
    rnd_in = 32'd3;  tick();
    chk("pre_rej", 32'(reject_count), 32'd2);
    chk("pre_head", out_data, 32'd1);
    out_ready = 1'b1;
    rnd_in = 32'd5;
    load(32'd17);
    chk("ld17_v", 32'(out_valid), 32'd0);
    chk("ld17_rej", 32'(reject_count), 32'd0);
    rnd_in = 32'h0000_0014; tick();
    chk("b17_rej_v", 32'(out_valid), 32'd0);
    chk("b17_rej_c", 32'(reject_count), 32'd1);
    rnd_in = 32'h0000_0010; tick();
    chk("b17_v", 32'(out_valid), 32'd1);
    chk("b17_d", out_data, 32'd16);

    // taus113 soak, bound=1000 (mask 0x3FF, ~97.7% acceptance).
    z1 = 32'hDEAD_BEEF; z2 = 32'hDEAD_BEEF; z3 = 32'hDEAD_BEEF; z4 = 32'hDEAD_BEEF;
    rnd_valid = 1'b0;
    load(32'd1000);
    tick();
    rnd_valid = 1'b1;
    accepted = 0; out_of_range = 0;
    for (int i = 0; i < 10000; i++) begin
      rnd_in = taus_next();
      tick();
      if (out_valid) begin
        accepted++;
        if (out_data >= 32'd1000) out_of_range++;
      end
    end
    chk("soak_range", 32'(out_of_range), 32'd0);
    chk("soak_sum", 32'(accepted) + 32'(reject_count), 32'd10000);
    chk("soak_rate", 32'(accepted >= 9600), 32'd1);

    // Asynchronous reset mid-stream, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rej", 32'(reject_count), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_noload", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
